// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: producer classes, forward-mux selects, pipeline slot record.
// Select values match the existing forwardmux encodings.
package fwd_pkg;

  localparam int SEL_W     = 3;
  // Slots store rd at a fixed width; instances require REG_AW <= SLOT_RD_W.
  localparam int SLOT_RD_W = 8;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_UIMM = 2'd2,
    KIND_BR   = 2'd3
  } prod_kind_t;

  typedef enum logic [SEL_W-1:0] {
    SEL_IDEX_RS    = 3'd0,
    SEL_EXMEM_ALU  = 3'd1,
    SEL_REGFILEMUX = 3'd2,
    SEL_MEM_RDATA  = 3'd3,
    SEL_MEM_UIMM   = 3'd4,
    SEL_CMP_BR     = 3'd5
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 wen;
    prod_kind_t           kind;
  } fwd_slot_t;

  localparam fwd_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage issue/source bundle toward the scoreboard and its stall/select answers.
// master = decode stage, slave = scoreboard.
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_wen;
  prod_kind_t                issue_kind;
  logic [NUM_SRC*REG_AW-1:0] src_rs;
  logic [NUM_SRC-1:0]        src_used;
  logic                      pipe_freeze;
  logic                      flush;
  logic                      load_stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

  modport master (
    output issue_valid, issue_rd, issue_wen, issue_kind, src_rs, src_used, pipe_freeze, flush,
    input  load_stall, fwd_sel
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wen, issue_kind, src_rs, src_used, pipe_freeze, flush,
    output load_stall, fwd_sel
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// One source channel: compares an ID operand against the EX and MEM producer slots.
// Purely combinational; the younger EX slot takes priority over MEM.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  fwd_slot_t         slot0,
  input  fwd_slot_t         slot1,
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  output fwd_sel_t          sel,
  output logic              load_hit
);

  logic [SLOT_RD_W-1:0] rs_ext;
  logic                 hit0;
  logic                 hit1;

  always_comb begin
    rs_ext             = '0;
    rs_ext[REG_AW-1:0] = rs;
  end

  assign hit0     = slot0.valid & slot0.wen & (slot0.rd != '0) & used & (slot0.rd == rs_ext);
  assign hit1     = slot1.valid & slot1.wen & (slot1.rd != '0) & used & (slot1.rd == rs_ext);
  assign load_hit = hit0 & (slot0.kind == KIND_LOAD);

  always_comb begin
    sel = SEL_IDEX_RS;
    if (hit0) begin
      // A load in EX resolves through the stall, so it leaves the select at idex_rs.
      case (slot0.kind)
        KIND_ALU:  sel = SEL_EXMEM_ALU;
        KIND_UIMM: sel = SEL_MEM_UIMM;
        KIND_BR:   sel = SEL_CMP_BR;
        default:   sel = SEL_IDEX_RS;
      endcase
    end else if (hit1) begin
      sel = SEL_REGFILEMUX;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX/MEM producer tracker: registered per-channel forward selects plus combinational load-use stall.
// pipe_freeze holds everything; define FWD_STATS_EN to add saturating stall/forward counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  fwd_scoreboard_if.slave   bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]       stat_stalls,
  output logic [31:0]       stat_fwds
`endif
);

  fwd_slot_t                slot0_q, slot0_d;
  fwd_slot_t                slot1_q, slot1_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0] sel_nxt;
  logic [NUM_SRC-1:0]       load_hit;
  fwd_slot_t                issue_slot;
  logic                     load_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    fwd_sel_t ch_sel;

    fwd_match #(.REG_AW(REG_AW)) u_match (
      .slot0    (slot0_q),
      .slot1    (slot1_q),
      .rs       (bus.src_rs[i*REG_AW +: REG_AW]),
      .used     (bus.src_used[i]),
      .sel      (ch_sel),
      .load_hit (load_hit[i])
    );

    assign sel_nxt[i*SEL_W +: SEL_W] = ch_sel;
  end

  assign load_stall     = ~bus.flush & (|load_hit);
  assign bus.load_stall = load_stall;
  assign bus.fwd_sel    = fwd_sel_q;

  always_comb begin
    issue_slot                = SLOT_EMPTY;
    issue_slot.valid          = bus.issue_valid;
    issue_slot.rd[REG_AW-1:0] = bus.issue_rd;
    issue_slot.wen            = bus.issue_wen;
    issue_slot.kind           = bus.issue_kind;
  end

  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    fwd_sel_d = fwd_sel_q;
    if (!bus.pipe_freeze) begin
      slot1_d = slot0_q;
      if (bus.flush || load_stall || !bus.issue_valid) begin
        slot0_d   = SLOT_EMPTY;
        fwd_sel_d = '0;
      end else begin
        slot0_d   = issue_slot;
        fwd_sel_d = sel_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q   <= SLOT_EMPTY;
      slot1_q   <= SLOT_EMPTY;
      fwd_sel_q <= '0;
    end else begin
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stat_stalls_q, stat_stalls_d;
  logic [31:0] stat_fwds_q, stat_fwds_d;

  always_comb begin
    stat_stalls_d = stat_stalls_q;
    stat_fwds_d   = stat_fwds_q;
    if (!bus.pipe_freeze) begin
      if (load_stall && (stat_stalls_q != '1)) stat_stalls_d = stat_stalls_q + 32'd1;
      if ((|fwd_sel_d) && (stat_fwds_q != '1)) stat_fwds_d = stat_fwds_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stalls_q <= '0;
      stat_fwds_q   <= '0;
    end else begin
      stat_stalls_q <= stat_stalls_d;
      stat_fwds_q   <= stat_fwds_d;
    end
  end

  assign stat_stalls = stat_stalls_q;
  assign stat_fwds   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed vector bench for fwd_scoreboard; stat counters are checked when FWD_STATS_EN is defined.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  typedef struct {
    logic       iv;
    logic [4:0] rd;
    logic       wen;
    logic [1:0] kind;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic       frz;
    logic       fl;
    logic       exp_stall;
    logic [8:0] exp_sel;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  fwd_scoreboard_if #(.NUM_SRC(2), .REG_AW(5)) bus ();

`ifdef FWD_STATS_EN
  logic [31:0] stat_stalls;
  logic [31:0] stat_fwds;
`endif

  fwd_scoreboard #(.NUM_SRC(2), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FWD_STATS_EN
    ,
    .stat_stalls (stat_stalls),
    .stat_fwds   (stat_fwds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic wen,
                              input logic [1:0] kind, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [1:0] used, input logic frz, input logic fl,
                              input logic exp_stall, input logic [8:0] exp_sel);
    vec_t v;
    v.iv = iv; v.rd = rd; v.wen = wen; v.kind = kind; v.rs0 = rs0; v.rs1 = rs1;
    v.used = used; v.frz = frz; v.fl = fl; v.exp_stall = exp_stall; v.exp_sel = exp_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.rd;
    bus.issue_wen   = v.wen;
    bus.issue_kind  = prod_kind_t'(v.kind);
    bus.src_rs      = {v.rs1, v.rs0};
    bus.src_used    = v.used;
    bus.pipe_freeze = v.frz;
    bus.flush       = v.fl;
  endtask

  task automatic apply(input string tag, input int idx, input vec_t v);
    drive(v);
    @(negedge clk);
    check($sformatf("%s[%0d].load_stall", tag, idx), {31'd0, bus.load_stall}, {31'd0, v.exp_stall});
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].fwd_sel", tag, idx), {23'd0, bus.fwd_sel}, {23'd0, v.exp_sel});
  endtask

  vec_t vecs[31];
  vec_t rvec[3];
  vec_t svec[6];

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 9'h000));

    //        iv rd  wen k  rs0 rs1 used   frz fl stall sel
    vecs[0]  = mk(1, 5,  1, 0, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[1]  = mk(1, 10, 1, 0, 5,  0,  2'b01, 0, 0, 0, 9'h001);
    vecs[2]  = mk(1, 11, 1, 0, 5,  0,  2'b01, 0, 0, 0, 9'h002);
    vecs[3]  = mk(1, 12, 1, 0, 5,  0,  2'b01, 0, 0, 0, 9'h000);
    vecs[4]  = mk(1, 6,  1, 1, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[5]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 1, 9'h000);
    vecs[6]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 0, 9'h010);
    vecs[7]  = mk(1, 7,  1, 0, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[8]  = mk(1, 7,  1, 2, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[9]  = mk(1, 14, 1, 0, 7,  7,  2'b11, 0, 0, 0, 9'h024);
    vecs[10] = mk(1, 15, 1, 3, 7,  0,  2'b01, 0, 0, 0, 9'h002);
    vecs[11] = mk(1, 0,  1, 0, 15, 14, 2'b11, 0, 0, 0, 9'h015);
    vecs[12] = mk(1, 9,  1, 0, 0,  0,  2'b01, 0, 0, 0, 9'h000);
    vecs[13] = mk(1, 16, 1, 0, 9,  9,  2'b00, 0, 0, 0, 9'h000);
    vecs[14] = mk(1, 9,  1, 1, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[15] = mk(1, 17, 1, 0, 9,  9,  2'b00, 0, 0, 0, 9'h000);
    vecs[16] = mk(1, 18, 0, 0, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[17] = mk(1, 19, 1, 0, 18, 17, 2'b11, 0, 0, 0, 9'h010);
    vecs[18] = mk(1, 6,  1, 1, 0,  0,  2'b00, 0, 1, 0, 9'h000);
    vecs[19] = mk(1, 20, 1, 0, 6,  0,  2'b01, 0, 0, 0, 9'h000);
    vecs[20] = mk(1, 6,  1, 1, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    vecs[21] = mk(1, 21, 1, 0, 6,  0,  2'b01, 0, 1, 0, 9'h000);
    vecs[22] = mk(1, 22, 1, 0, 6,  0,  2'b01, 0, 0, 0, 9'h002);
    vecs[23] = mk(1, 23, 1, 0, 22, 0,  2'b01, 0, 0, 0, 9'h001);
    vecs[24] = mk(1, 24, 1, 0, 22, 0,  2'b01, 1, 0, 0, 9'h001);
    vecs[25] = mk(1, 24, 1, 0, 22, 0,  2'b01, 1, 0, 0, 9'h001);
    vecs[26] = mk(1, 24, 1, 0, 22, 0,  2'b01, 1, 0, 0, 9'h001);
    vecs[27] = mk(1, 24, 1, 0, 22, 0,  2'b01, 0, 0, 0, 9'h002);
    vecs[28] = mk(1, 25, 1, 0, 24, 0,  2'b01, 0, 0, 0, 9'h001);
    vecs[29] = mk(0, 0,  0, 0, 25, 0,  2'b01, 0, 0, 0, 9'h000);
    vecs[30] = mk(1, 26, 1, 0, 25, 0,  2'b01, 0, 0, 0, 9'h002);

    rvec[0]  = mk(1, 5,  1, 0, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    rvec[1]  = mk(1, 6,  1, 1, 5,  0,  2'b01, 0, 0, 0, 9'h001);
    rvec[2]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 1, 9'h001);

    svec[0]  = mk(1, 6,  1, 1, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    svec[1]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 1, 9'h000);
    svec[2]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 0, 9'h010);
    svec[3]  = mk(1, 6,  1, 1, 0,  0,  2'b00, 0, 0, 0, 9'h000);
    svec[4]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 1, 9'h000);
    svec[5]  = mk(1, 13, 1, 0, 0,  6,  2'b10, 0, 0, 0, 9'h010);

    #8;
    check("reset.fwd_sel", {23'd0, bus.fwd_sel}, 32'd0);
    check("reset.load_stall", {31'd0, bus.load_stall}, 32'd0);
`ifdef FWD_STATS_EN
    check("reset.stat_stalls", stat_stalls, 32'd0);
    check("reset.stat_fwds", stat_fwds, 32'd0);
`endif
    #4;
    rst = 1'b0;

    for (int i = 0; i < 31; i++) apply("vec", i, vecs[i]);

    // Build a stall with a live non-zero select, then hit reset mid-cycle.
    apply("rst_setup", 0, rvec[0]);
    apply("rst_setup", 1, rvec[1]);
    drive(rvec[2]);
    @(negedge clk);
    check("pre_rst.load_stall", {31'd0, bus.load_stall}, 32'd1);
    check("pre_rst.fwd_sel", {23'd0, bus.fwd_sel}, 32'h001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.load_stall", {31'd0, bus.load_stall}, 32'd0);
    check("async_rst.fwd_sel", {23'd0, bus.fwd_sel}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply("stats", i, svec[i]);
`ifdef FWD_STATS_EN
    check("stat_stalls", stat_stalls, 32'd2);
    check("stat_fwds", stat_fwds, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
